router_pkt_fifo: RTL and testbench
==================================

ROUTER_PKT_FIFO -- requirements
Module: router_pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload byte width (min 4).
REQ-002 SHALL have parameter DEPTH, default 16, entry count (power of two, 4..256).
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, almost_full threshold in entries.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have port sft_rst, input, 1, synchronous active-high soft reset (time-out flush).
REQ-007 SHALL have ports write_enb, read_enb, input, 1 each, write/read requests.
REQ-008 SHALL have port lfd_state, input, 1, marks data_in as header byte in same cycle.
REQ-009 SHALL have port data_in, input, DATA_W, write data.
REQ-010 SHALL have port data_out, output, DATA_W, registered read data.
REQ-011 SHALL have ports empty, full, almost_full, output, 1 each, combinational status.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1, occupied entries.
REQ-013 SHALL have port pkt_done, output, 1, one-cycle pulse on last byte of packet read.

Function
REQ-014 Storage SHALL be DEPTH entries of DATA_W+1 bits: {header flag, data}, header flag = lfd_state sampled with the write.
REQ-015 Pointers SHALL be $clog2(DEPTH)+1 bits, address with low bits, wrap modulo 2*DEPTH.
REQ-016 empty SHALL be 1 when pointers equal; full when low bits equal and MSBs differ; count = wptr-rptr; almost_full = count >= AFULL_TH.
REQ-017 Write accepted iff write_enb && !full; otherwise write ignored, no state change.
REQ-018 Read accepted iff read_enb && !empty; data_out updates at next rising edge (1-cycle latency).
REQ-019 Simultaneous read and write SHALL both be accepted when neither full nor empty; when full only read proceeds; when empty only write proceeds (status from pre-edge values).
REQ-020 On reading a header entry, remaining-byte counter SHALL load data[DATA_W-1:2]+1 (payload + parity); each later accepted read decrements it while nonzero.
REQ-021 pkt_done SHALL pulse the cycle after reading the entry that brings the counter from 1 to 0.
REQ-022 When counter is 0 and no read is accepted, data_out SHALL go to idle value (see REQ-029/030) on next edge.
REQ-023 Header read while counter nonzero SHALL reload counter (truncated packet), no pkt_done.

Reset
REQ-024 rst low SHALL clear pointers, counter, pkt_done, data_out=0, memory contents to 0; rst has priority over sft_rst.
REQ-025 sft_rst SHALL clear both pointers, counter and pkt_done, drive data_out to idle value; memory need not be cleared.
REQ-026 sft_rst SHALL override concurrent read/write in the same cycle.
REQ-027 After either reset: empty=1, full=0, almost_full=0, count=0.

Configuration
REQ-028 Macro ROUTER_FIFO_TRISTATE_EN SHALL select idle drive of data_out.
REQ-029 Defined: idle value is all-z (shared output bus).
REQ-030 Undefined: idle value is all-zero; no z in design.

Verification
REQ-031 Reset then write header 0x0C (len 3) + 3 payload + parity, read 5 -> data in order, pkt_done one cycle after 5th read, data_out idle next cycle.
REQ-032 Write 16 entries (DEPTH=16) -> full=1, count=16, almost_full=1 from count 14; 17th write ignored, read returns first byte.
REQ-033 Full FIFO with read_enb and write_enb both high -> count 15, full=0, written byte not stored.
REQ-034 20 write/read pairs at steady state -> pointer wrap, data integrity, count constant.
REQ-035 sft_rst mid-packet after 3 writes, 1 read -> empty=1, count=0, data_out idle, pkt_done=0; next packet reads correctly.
REQ-036 read_enb on empty FIFO -> no pointer change, data_out held/idle, empty stays 1.

Source files
------------

// File: rtl/router_pkt_fifo.sv
// Packet FIFO for the router: header-tagged storage, byte-count tracking, pkt_done pulse.
// Define ROUTER_FIFO_TRISTATE_EN to float data_out (all-z) when idle; otherwise idle drives zero.
module router_pkt_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sft_rst,
  input  logic                       write_enb,
  input  logic                       read_enb,
  input  logic                       lfd_state,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       pkt_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = DATA_W - 1;
  localparam logic [PW-1:0] AFULL_V = PW'(AFULL_TH);

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [DATA_W:0]   mem_d [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic              pkt_done_q, pkt_done_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W:0]   rd_entry;
`ifdef ROUTER_FIFO_TRISTATE_EN
  logic              idle_q, idle_d;
`endif

  assign count       = wptr_q - rptr_q;
  assign empty       = (wptr_q == rptr_q);
  assign full        = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign almost_full = (count >= AFULL_V);
  assign pkt_done    = pkt_done_q;
  assign rd_entry    = mem_q[rptr_q[AW-1:0]];

`ifdef ROUTER_FIFO_TRISTATE_EN
  assign data_out = idle_q ? {DATA_W{1'bz}} : dout_q;
`else
  assign data_out = dout_q;
`endif

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rem_d      = rem_q;
    dout_d     = dout_q;
    pkt_done_d = 1'b0;
`ifdef ROUTER_FIFO_TRISTATE_EN
    idle_d     = idle_q;
`endif
    // soft reset wins over any concurrent request
    wr_acc = write_enb && !full && !sft_rst;
    rd_acc = read_enb && !empty && !sft_rst;

    if (wr_acc) begin
      mem_d[wptr_q[AW-1:0]] = {lfd_state, data_in};
      wptr_d                = wptr_q + PW'(1);
    end

    if (rd_acc) begin
      rptr_d = rptr_q + PW'(1);
      dout_d = rd_entry[DATA_W-1:0];
`ifdef ROUTER_FIFO_TRISTATE_EN
      idle_d = 1'b0;
`endif
      // header reload covers truncated packets: no pulse for the abandoned one
      if (rd_entry[DATA_W]) begin
        rem_d = {1'b0, rd_entry[DATA_W-1:2]} + CW'(1);
      end else if (rem_q != '0) begin
        rem_d      = rem_q - CW'(1);
        pkt_done_d = (rem_q == CW'(1));
      end
    end else if (rem_q == '0) begin
      dout_d = '0;
`ifdef ROUTER_FIFO_TRISTATE_EN
      idle_d = 1'b1;
`endif
    end

    if (sft_rst) begin
      wptr_d     = '0;
      rptr_d     = '0;
      rem_d      = '0;
      pkt_done_d = 1'b0;
      dout_d     = '0;
`ifdef ROUTER_FIFO_TRISTATE_EN
      idle_d     = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      rem_q      <= '0;
      pkt_done_q <= 1'b0;
      dout_q     <= '0;
`ifdef ROUTER_FIFO_TRISTATE_EN
      idle_q     <= 1'b0;
`endif
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rem_q      <= rem_d;
      pkt_done_q <= pkt_done_d;
      dout_q     <= dout_d;
`ifdef ROUTER_FIFO_TRISTATE_EN
      idle_q     <= idle_d;
`endif
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Bench for router_pkt_fifo (DATA_W=8, DEPTH=16): scoreboard queue plus a hand-derived vector table.
module tb_router_pkt_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sft_rst = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       empty, full, almost_full, pkt_done;
  logic [4:0] count;

  router_pkt_fifo dut (
    .clk(clk), .rst(rst), .sft_rst(sft_rst),
    .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
    .data_in(data_in), .data_out(data_out),
    .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] sb[$];
  int         m_count = 0;
  int         m_rem = 0;
  logic [7:0] m_dout = '0;
  bit         m_pkt = 0;

  typedef struct {
    bit         wr;
    bit         rd;
    bit         lfd;
    logic [7:0] din;
    int         exp_count;
    logic [7:0] exp_dout;
    bit         exp_pkt;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit wr, input bit rd, input bit lfd, input logic [7:0] din, input bit srst);
    bit wacc, racc;
    logic [8:0] ent;
    @(negedge clk);
    write_enb = wr; read_enb = rd; lfd_state = lfd; data_in = din; sft_rst = srst;
    wacc  = wr && (m_count < 16) && !srst;
    racc  = rd && (m_count > 0) && !srst;
    m_pkt = 0;
    if (srst) begin
      sb.delete();
      m_count = 0; m_rem = 0; m_dout = '0;
    end else begin
      if (racc) begin
        ent    = sb.pop_front();
        m_dout = ent[7:0];
        if (ent[8]) m_rem = int'(ent[7:2]) + 1;
        else if (m_rem != 0) begin
          m_pkt = (m_rem == 1);
          m_rem--;
        end
      end else if (m_rem == 0) m_dout = '0;
      if (wacc) sb.push_back({lfd, din});
      m_count = m_count + int'(wacc) - int'(racc);
    end
    @(posedge clk); #1;
    chk("count", count, m_count);
    chk("empty", empty, m_count == 0);
    chk("full", full, m_count == 16);
    chk("almost_full", almost_full, m_count >= 14);
    chk("data_out", data_out, m_dout);
    chk("pkt_done", pkt_done, m_pkt);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b0; write_enb = 0; read_enb = 0; sft_rst = 0;
    @(posedge clk); #1;
    sb.delete(); m_count = 0; m_rem = 0; m_dout = '0; m_pkt = 0;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_pkt", pkt_done, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    vt[0]  = '{1, 0, 1, 8'h0C, 1, 8'h00, 0};
    vt[1]  = '{1, 0, 0, 8'hA1, 2, 8'h00, 0};
    vt[2]  = '{1, 0, 0, 8'hA2, 3, 8'h00, 0};
    vt[3]  = '{1, 0, 0, 8'hA3, 4, 8'h00, 0};
    vt[4]  = '{1, 0, 0, 8'h5E, 5, 8'h00, 0};
    vt[5]  = '{0, 1, 0, 8'h00, 4, 8'h0C, 0};
    vt[6]  = '{0, 1, 0, 8'h00, 3, 8'hA1, 0};
    vt[7]  = '{0, 1, 0, 8'h00, 2, 8'hA2, 0};
    vt[8]  = '{0, 1, 0, 8'h00, 1, 8'hA3, 0};
    vt[9]  = '{0, 1, 0, 8'h00, 0, 8'h5E, 1};
    vt[10] = '{0, 0, 0, 8'h00, 0, 8'h00, 0};

    repeat (2) @(posedge clk);
    hard_reset();

    // single packet: header 0x0C -> 3 payload + parity
    for (int i = 0; i < 11; i++) begin
      step(vt[i].wr, vt[i].rd, vt[i].lfd, vt[i].din, 0);
      chk($sformatf("vec%0d_count", i), count, vt[i].exp_count);
      chk($sformatf("vec%0d_dout", i), data_out, vt[i].exp_dout);
      chk($sformatf("vec%0d_pkt", i), pkt_done, vt[i].exp_pkt);
    end

    // fill to full, threshold crossing, overflow attempt
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 8'h10 + 8'(i), 0);
      if (i == 12) chk("afull_at13", almost_full, 0);
      if (i == 13) chk("afull_at14", almost_full, 1);
    end
    chk("full_16", full, 1);
    step(1, 0, 0, 8'hEE, 0);
    chk("overflow_count", count, 16);
    step(1, 1, 0, 8'hDD, 0);
    chk("rw_on_full_count", count, 15);
    chk("rw_on_full_full", full, 0);
    chk("rw_on_full_dout", data_out, 8'h10);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 8'h00, 0);
    chk("drained_empty", empty, 1);
    step(0, 0, 0, 8'h00, 0);

    // steady-state write/read pairs wrap the pointers
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h60 + 8'(i), 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 8'($urandom_range(0, 255)), 0);
      chk("steady_count", count, 4);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);

    // truncated packet: second header reloads the counter mid-packet
    step(1, 0, 1, 8'h0C, 0);
    step(1, 0, 0, 8'hB1, 0);
    step(1, 0, 1, 8'h04, 0);
    step(1, 0, 0, 8'hB2, 0);
    step(1, 0, 0, 8'hB3, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00, 0);
    chk("trunc_pkt", pkt_done, 1);
    step(0, 0, 0, 8'h00, 0);

    // soft reset mid-packet, overriding a concurrent read and write
    step(1, 0, 1, 8'h08, 0);
    step(1, 0, 0, 8'h21, 0);
    step(1, 0, 0, 8'h22, 0);
    step(0, 1, 0, 8'h00, 0);
    step(1, 1, 0, 8'h33, 1);
    chk("srst_empty", empty, 1);
    chk("srst_count", count, 0);
    chk("srst_dout", data_out, 0);
    chk("srst_pkt", pkt_done, 0);
    step(1, 0, 1, 8'h04, 0);
    step(1, 0, 0, 8'h41, 0);
    step(1, 0, 0, 8'h42, 0);
    step(0, 1, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 0);
    chk("post_srst_pkt", pkt_done, 1);
    chk("post_srst_dout", data_out, 8'h42);

    // read on empty
    step(0, 1, 0, 8'h00, 0);
    chk("rd_empty_empty", empty, 1);
    chk("rd_empty_dout", data_out, 0);

    // hard reset with data in flight
    step(1, 0, 0, 8'h77, 0);
    step(1, 0, 0, 8'h78, 0);
    hard_reset();
    step(1, 0, 0, 8'h99, 0);
    step(0, 1, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
